spi_cmd_dispatch: RTL

Command dispatcher directly downstream of the SPI capture controller. It takes each captured 24-bit SPI word (presented on `spi_out`, flagged by `cap_en`) and queues it in a 4-entry FIFO. It decodes the target field, issues a one-cycle start pulse with operands to the ALU or MAC, and waits for that unit's done handshake before issuing the next command. Its `aluop_st`/`macop_st` outputs drive the SPI controller's start inputs of the same names.

---
 rtl/spi_cmd_dispatch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_dispatch.sv
// Command dispatcher behind the SPI capture controller: queues captured words,
// decodes the target and drives one start pulse at a time to the ALU or MAC.
module spi_cmd_dispatch #(
  parameter int DEPTH = 4,
  parameter int TMO   = 255
) (
  input  logic        spi_clk_i,
  input  logic        rst_i,
  input  logic        cap_en_i,
  input  logic [23:0] spi_out_i,
  input  logic        alu_done_i,
  input  logic        mac_done_i,
  output logic        aluop_st_o,
  output logic        macop_st_o,
  output logic        mac_clr_o,
  output logic [5:0]  op_code_o,
  output logic [7:0]  op_a_o,
  output logic [7:0]  op_b_o,
  output logic        busy_o,
  output logic        fifo_full_o,
  output logic        fifo_empty_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic [3:0]  illegal_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic            cap_q;
  logic [23:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [5:0]      op_code_q, op_code_d;
  logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic            aluop_q, aluop_d, macop_q, macop_d, mclr_q, mclr_d;
  logic            overflow_q, overflow_d, timeout_q, timeout_d;
  logic [3:0]      illegal_q, illegal_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic            push, pop, full, push_ok, done;
  logic [23:0]     head;

  assign push    = cap_en_i & ~cap_q;
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  // A push into a full FIFO still lands when the same cycle frees a slot.
  assign push_ok = push && (!full || pop);
  assign head    = mem_q[rd_ptr_q];
  assign done    = (tgt_q == 2'b00) ? alu_done_i : mac_done_i;

  always_ff @(posedge spi_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= spi_out_i;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tgt_d      = tgt_q;
    op_code_d  = op_code_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    aluop_d    = 1'b0;
    macop_d    = 1'b0;
    mclr_d     = 1'b0;
    overflow_d = overflow_q | (push & ~push_ok);
    timeout_d  = timeout_q;
    illegal_d  = illegal_q;
    tmo_cnt_d  = tmo_cnt_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head[23:22] == 2'b11) begin
            if (illegal_q != 4'hF) illegal_d = illegal_q + 4'd1;
          end else begin
            tgt_d     = head[23:22];
            op_code_d = head[21:16];
            op_a_d    = head[15:8];
            op_b_d    = head[7:0];
            aluop_d   = (head[23:22] == 2'b00);
            macop_d   = (head[23:22] != 2'b00);
            mclr_d    = (head[23:22] == 2'b10);
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_IDLE;
        end else if (tmo_cnt_q == TW'(TMO - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cap_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tgt_q      <= 2'b00;
      op_code_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      aluop_q    <= 1'b0;
      macop_q    <= 1'b0;
      mclr_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      illegal_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_en_i;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tgt_q      <= tgt_d;
      op_code_q  <= op_code_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      aluop_q    <= aluop_d;
      macop_q    <= macop_d;
      mclr_q     <= mclr_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      illegal_q  <= illegal_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign aluop_st_o    = aluop_q;
  assign macop_st_o    = macop_q;
  assign mac_clr_o     = mclr_q;
  assign op_code_o     = op_code_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign fifo_full_o   = full;
  assign fifo_empty_o  = (count_q == '0);
  assign overflow_o    = overflow_q;
  assign timeout_o     = timeout_q;
  assign illegal_cnt_o = illegal_q;

endmodule
